// File: rtl/can_sched_pkg.sv
// can_sched_pkg: shared state type, frame geometry and identifier helper for the CAN transmit scheduler
package can_sched_pkg;
  localparam int FRAME_W = 108;
  localparam int ID_W = 11;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, DONE} state_t;
  function automatic logic [ID_W-1:0] frame_id(input logic [FRAME_W-1:0] frame);
    return frame[FRAME_W-1 -: ID_W];
  endfunction
endpackage

// File: rtl/can_prio_select.sv
// can_prio_select: picks the full mailbox with the lowest identifier (ties to lowest index); ports full/ids in, idx/any_full out
module can_prio_select
  import can_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]      full,
  input  logic [N_REQ*ID_W-1:0] ids,
  output logic [GW-1:0]         idx,
  output logic                  any_full
);
  logic [ID_W-1:0] best;
  always_comb begin
    idx = '0;
    any_full = 1'b0;
    best = '1;
    for (int i = 0; i < N_REQ; i++)
      if (full[i] && (!any_full || ids[i*ID_W +: ID_W] < best)) begin
        idx = GW'(i);
        any_full = 1'b1;
        best = ids[i*ID_W +: ID_W];
      end
  end
endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares one can_controller tx path among N_REQ one-frame mailboxes, lowest CAN id first.
// Ports: GCLK/RES clock and async reset; req_valid/req_ready/req_frame mailbox load; done/err per-mailbox pulses;
// can_din/can_tx_start/can_tx_ready controller handshake; busy (not IDLE); grant_idx current/last grant.
// Option: define CAN_SCHED_RETRY_EN to retry a timed-out frame up to 4 attempts before reporting err.
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                       GCLK,
  input  logic                       RES,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*FRAME_W-1:0]   req_frame,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic [FRAME_W-1:0]         can_din,
  output logic                       can_tx_start,
  input  logic                       can_tx_ready,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_idx
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [FRAME_W-1:0] mb [N_REQ];
  logic [N_REQ-1:0] full;
  logic [N_REQ*ID_W-1:0] ids;
  logic [GW-1:0] sel;
  logic any_full;
  logic [CW-1:0] cnt;
  logic tmo, drop;
  state_t state, nxt;
  always_comb begin
    ids = '0;
    for (int i = 0; i < N_REQ; i++) ids[i*ID_W +: ID_W] = frame_id(mb[i]);
  end
  can_prio_select #(.N_REQ(N_REQ), .GW(GW)) u_sel (
    .full(full), .ids(ids), .idx(sel), .any_full(any_full)
  );
  // tmo fires on the TIMEOUT_CYC-th cycle spent in START/WAIT since the last ARB
  assign tmo = (state == START || state == WAIT) && cnt == CW'(TIMEOUT_CYC - 1);
`ifdef CAN_SCHED_RETRY_EN
  // drop only on the 4th consecutive timeout; the counter wraps to 0 exactly then
  logic [1:0] rc [N_REQ];
  always_ff @(posedge GCLK or posedge RES)
    if (RES) for (int i = 0; i < N_REQ; i++) rc[i] <= '0;
    else if (state == DONE) rc[grant_idx] <= '0;
    else if (tmo) rc[grant_idx] <= rc[grant_idx] + 2'd1;
  assign drop = tmo && rc[grant_idx] == 2'd3;
`else
  assign drop = tmo;
`endif
  always_ff @(posedge GCLK or posedge RES)
    if (RES) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (any_full && can_tx_ready) ? ARB : IDLE;
      ARB:     nxt = START;
      START:   nxt = tmo ? IDLE : (!can_tx_ready ? WAIT : START);
      WAIT:    nxt = tmo ? IDLE : (can_tx_ready ? DONE : WAIT);
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    can_tx_start = state == START;
    busy = state != IDLE;
    done = (state == DONE) ? N_REQ'(1) << grant_idx : '0;
    req_ready = ~full;
  end
  always_ff @(posedge GCLK or posedge RES)
    if (RES) begin
      can_din <= '0;
      grant_idx <= '0;
      cnt <= '0;
      err <= '0;
    end else begin
      err <= drop ? N_REQ'(1) << grant_idx : '0;
      cnt <= (state == ARB) ? '0 : (state == START || state == WAIT) ? cnt + CW'(1) : cnt;
      if (state == ARB) begin
        grant_idx <= sel;
        can_din <= mb[sel];
      end
    end
  // a mailbox being emptied is always full, so load and clear never coincide
  always_ff @(posedge GCLK or posedge RES)
    if (RES) full <= '0;
    else
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && !full[i]) full[i] <= 1'b1;
        else if (GW'(i) == grant_idx && (state == DONE || drop)) full[i] <= 1'b0;
  always_ff @(posedge GCLK)
    for (int i = 0; i < N_REQ; i++)
      if (req_valid[i] && !full[i]) mb[i] <= req_frame[i*FRAME_W +: FRAME_W];
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: scoreboard bench for can_tx_scheduler with a simple can_controller model
module tb_can_tx_scheduler;
  localparam int TO = 600;
`ifdef CAN_SCHED_RETRY_EN
  localparam int ATT = 4;
`else
  localparam int ATT = 1;
`endif
  typedef struct {bit is_err; int idx; logic [107:0] frame;} exp_t;
  logic GCLK = 0, RES = 1, can_tx_start, can_tx_ready = 1, busy;
  logic [3:0] req_valid = '0, req_ready, done, err;
  logic [431:0] req_frame = '0;
  logic [107:0] can_din;
  logic [1:0] grant_idx;
  exp_t q[$];
  int nvec = 0, nerr = 0;
  bit stuck = 0;
  can_tx_scheduler #(.N_REQ(4), .TIMEOUT_CYC(TO)) dut (
    .GCLK(GCLK), .RES(RES), .req_valid(req_valid), .req_ready(req_ready), .req_frame(req_frame),
    .done(done), .err(err), .can_din(can_din), .can_tx_start(can_tx_start),
    .can_tx_ready(can_tx_ready), .busy(busy), .grant_idx(grant_idx)
  );
  always #5 GCLK = ~GCLK;
  function automatic logic [107:0] mk(input logic [10:0] id, input logic [31:0] tag);
    return {id, {65{1'b1}}, tag};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input bit e, input int i, input logic [107:0] f);
    exp_t x;
    x.is_err = e; x.idx = i; x.frame = f;
    q.push_back(x);
  endtask
  task automatic set_slot(input int i, input logic [107:0] f);
    req_frame[i*108 +: 108] = f;
    req_valid[i] = 1'b1;
  endtask
  task automatic pulse();
    @(posedge GCLK); #1;
    req_valid = '0;
  endtask
  task automatic wait_idle(input int bound, input string nm);
    nvec++;
    for (int k = 0; k < bound; k++) begin
      @(negedge GCLK);
      if (q.size() == 0 && !busy) return;
    end
    nerr++;
    $display("FAIL %s: still busy=%b with %0d pending after %0d cycles, required idle", nm, busy, q.size(), bound);
  endtask
  task automatic wait_ready_low(input int bound, input string nm);
    nvec++;
    for (int k = 0; k < bound; k++) begin
      @(negedge GCLK);
      if (!can_tx_ready) return;
    end
    nerr++;
    $display("FAIL %s: can_tx_ready stayed 1 for %0d cycles, required 0", nm, bound);
  endtask
  // controller model: accepts 10 cycles after tx_start, completes 500 cycles later
  initial begin
    int ph, cc;
    ph = 0; cc = 0;
    forever begin
      @(posedge GCLK); #1;
      if (RES) begin
        ph = 0; can_tx_ready = 1;
      end else if (ph == 0) begin
        if (can_tx_start && !stuck) begin ph = 1; cc = 1; end
      end else if (ph == 1) begin
        cc++;
        if (cc == 10) begin can_tx_ready = 0; ph = 2; cc = 0; end
      end else begin
        cc++;
        if (cc == 500) begin can_tx_ready = 1; ph = 0; end
      end
    end
  end
  initial begin
    forever begin
      @(negedge GCLK);
      if (done != 0 || err != 0) begin
        nvec++;
        if (done != 0 && err != 0) begin
          nerr++;
          $display("FAIL scoreboard: done=%b and err=%b together, required exclusive", done, err);
        end else if (q.size() == 0) begin
          nerr++;
          $display("FAIL scoreboard: unexpected done=%b err=%b, required none", done, err);
        end else begin
          exp_t e;
          logic [3:0] ev;
          e = q.pop_front();
          ev = 4'(1) << e.idx;
          if ((err != 0) != e.is_err || (e.is_err ? err : done) != ev || can_din !== e.frame) begin
            nerr++;
            $display("FAIL scoreboard: got done=%b err=%b din=%h, required %s=%b din=%h",
                     done, err, can_din, e.is_err ? "err" : "done", ev, e.frame);
          end
        end
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [107:0] f;
    int cyc, starts, hi;
    bit prev, seen;
    #3;
    chk("reset_ready", req_ready, 4'hF);
    chk("reset_done_err", {done, err}, 8'h00);
    chk("reset_start_busy", {can_tx_start, busy}, 2'b00);
    chk("reset_din", can_din, 108'h0);
    chk("reset_grant", grant_idx, 2'd0);
    repeat (2) @(posedge GCLK);
    #1 RES = 0;
    // single frame
    @(negedge GCLK);
    f = mk(11'h123, 32'h0000_0002);
    set_slot(2, f);
    push(0, 2, f);
    pulse();
    chk("load_ready_drop", req_ready, 4'b1011);
    cyc = 0; seen = 0;
    for (int k = 0; k < 700 && !seen; k++) begin
      @(negedge GCLK);
      cyc++;
      if (can_tx_start && cyc < 5) begin
        chk("grant_idx_single", grant_idx, 2'd2);
        chk("din_single", can_din, f);
      end
      if (done[2]) seen = 1;
    end
    chk("done_latency", cyc, 513);
    @(negedge GCLK);
    chk("ready_after_done", req_ready, 4'hF);
    wait_idle(100, "single_idle");
    // priority: ids 0x300/0x010/0x010 in mailboxes 0/1/3
    set_slot(0, mk(11'h300, 32'h0000_0010));
    set_slot(1, mk(11'h010, 32'h0000_0011));
    set_slot(3, mk(11'h010, 32'h0000_0013));
    push(0, 1, mk(11'h010, 32'h0000_0011));
    push(0, 3, mk(11'h010, 32'h0000_0013));
    push(0, 0, mk(11'h300, 32'h0000_0010));
    pulse();
    chk("prio_ready", req_ready, 4'b0100);
    wait_idle(3000, "prio_idle");
    // late arrival with a higher-priority id while mailbox 0 is in WAIT
    @(negedge GCLK);
    set_slot(0, mk(11'h7FF, 32'h0000_0020));
    push(0, 0, mk(11'h7FF, 32'h0000_0020));
    pulse();
    wait_ready_low(100, "late_wait");
    set_slot(3, mk(11'h001, 32'h0000_0023));
    push(0, 3, mk(11'h001, 32'h0000_0023));
    pulse();
    chk("late_grant_held", grant_idx, 2'd0);
    wait_idle(2000, "late_idle");
    // timeout: controller never accepts
    stuck = 1;
    @(negedge GCLK);
    set_slot(1, mk(11'h055, 32'h0000_0031));
    push(1, 1, mk(11'h055, 32'h0000_0031));
    pulse();
    starts = 0; hi = 0; prev = 0; seen = 0;
    for (int k = 0; k < ATT * TO + 100 && !seen; k++) begin
      @(negedge GCLK);
      if (can_tx_start) begin hi++; if (!prev) starts++; end
      prev = can_tx_start;
      if (err != 0) seen = 1;
    end
    chk("timeout_err_seen", seen, 1'b1);
    chk("timeout_attempts", starts, ATT);
    chk("timeout_start_cycles", hi, ATT * TO);
    @(negedge GCLK);
    chk("timeout_ready", req_ready, 4'hF);
    stuck = 0;
    wait_idle(100, "timeout_idle");
    // reset during WAIT
    @(negedge GCLK);
    set_slot(2, mk(11'h222, 32'h0000_0042));
    pulse();
    wait_ready_low(100, "rst_wait");
    #2 RES = 1;
    #1;
    chk("rst_start", can_tx_start, 1'b0);
    chk("rst_ready", req_ready, 4'hF);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(posedge GCLK);
    #3 RES = 0;
    @(negedge GCLK);
    set_slot(0, mk(11'h0AB, 32'h0000_0050));
    push(0, 0, mk(11'h0AB, 32'h0000_0050));
    pulse();
    wait_idle(1000, "post_rst_idle");
    repeat (5) @(negedge GCLK);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
